// File: rtl/bw_io_bscan_pkg.sv
// -----------------------------------------------------------------------------
// bw_io_bscan_pkg
// Shared definitions for the boundary-scan sequencer: the state encoding
// constants and the FSM state enum built from them.
// -----------------------------------------------------------------------------
package bw_io_bscan_pkg;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_CAPTURE = 3'd1;
  localparam logic [2:0] ENC_SHIFT   = 3'd2;
  localparam logic [2:0] ENC_UPDATE  = 3'd3;
  localparam logic [2:0] ENC_DONE    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_CAPTURE = ENC_CAPTURE,
    ST_SHIFT   = ENC_SHIFT,
    ST_UPDATE  = ENC_UPDATE,
    ST_DONE    = ENC_DONE
  } state_t;

endpackage

// File: rtl/bw_io_bscan_seq_shreg.sv
// -----------------------------------------------------------------------------
// bw_io_bscan_seq_shreg
// CHAIN_LEN-bit load/shift register used by the boundary-scan sequencer.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (clears q)
//   load  - parallel load of din (priority over shift)
//   shift - shift right by one, sin enters at the MSB
//   sin   - serial input (chain return data)
//   din   - parallel load data
//   sout  - bit 0 of the register (next bit to drive into the chain)
//   q     - full register contents
// -----------------------------------------------------------------------------
module bw_io_bscan_seq_shreg #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 sin,
  input  logic [CHAIN_LEN-1:0] din,
  output logic                 sout,
  output logic [CHAIN_LEN-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    // NOTE: this register is a datapath register rather than a memory array,
    // so it is cheap to reset and a reset keeps rdata deterministic.
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[CHAIN_LEN-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/bw_io_bscan_seq.sv
// -----------------------------------------------------------------------------
// bw_io_bscan_seq
// Drives one capture / shift / update sequence on a boundary-scan chain of
// CHAIN_LEN cells. wdata is shifted in LSB first; the bits returning on bsr_so
// are collected so that rdata[0] is the first bit that came out of the chain.
// Start-to-done latency is CHAIN_LEN+3 cycles. All outputs are registered.
//
// Optional feature: define BW_IO_BSCAN_SEQ_ABORT_EN to add an abort input that
// cancels a sequence in CAPTURE or SHIFT (no update_dr, no done, rdata kept).
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - request a sequence (sampled only in IDLE)
//   wdata     - vector to shift in, bit 0 first
//   bsr_so    - serial output of the last chain cell
//   abort     - (BW_IO_BSCAN_SEQ_ABORT_EN only) cancel the running sequence
//   shift_dr  - chain shift (1) / capture (0) select
//   clock_dr  - chain clock enable, one pulse per chain advance
//   update_dr - transfer chain contents to the update latches
//   bsr_si    - serial data into the first chain cell
//   busy      - high in CAPTURE, SHIFT and UPDATE
//   done      - one-cycle completion pulse
//   rdata     - captured chain contents, held until the next done
// -----------------------------------------------------------------------------
module bw_io_bscan_seq
  import bw_io_bscan_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] wdata,
  input  logic                 bsr_so,
`ifdef BW_IO_BSCAN_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 shift_dr,
  output logic                 clock_dr,
  output logic                 update_dr,
  output logic                 bsr_si,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic                 abort_req;
  logic                 sr_load;
  logic                 sr_shift;
  logic                 sr_sout;
  logic [CHAIN_LEN-1:0] sr_q;

`ifdef BW_IO_BSCAN_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The register shifts on every SHIFT cycle, sampling bsr_so in step with the
  // chain advancing on the same edge.
  assign sr_load  = (state == ST_IDLE) && start;
  assign sr_shift = (state == ST_SHIFT);

  bw_io_bscan_seq_shreg #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .sin   (bsr_so),
    .din   (wdata),
    .sout  (sr_sout),
    .q     (sr_q)
  );

  // Outputs are computed for the state being entered, so they are valid for
  // the whole cycle spent in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shift_dr  <= 1'b0;
      clock_dr  <= 1'b0;
      update_dr <= 1'b0;
      bsr_si    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      // NOTE: every control output gets a default here, so each state only
      // names the signals it raises and nothing holds a stale value.
      shift_dr  <= 1'b0;
      clock_dr  <= 1'b0;
      update_dr <= 1'b0;
      bsr_si    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_CAPTURE;
            cnt      <= '0;
            clock_dr <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ST_CAPTURE: begin
          if (abort_req) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_SHIFT;
            cnt      <= '0;
            clock_dr <= 1'b1;
            shift_dr <= 1'b1;
            busy     <= 1'b1;
            bsr_si   <= sr_sout;
          end
        end

        ST_SHIFT: begin
          if (abort_req) begin
            state <= ST_IDLE;
          end else begin
            // Counter never exceeds CHAIN_LEN, which CNT_W always holds.
            cnt  <= cnt + CNT_W'(1);
            busy <= 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= ST_UPDATE;
              update_dr <= 1'b1;
            end else begin
              clock_dr <= 1'b1;
              shift_dr <= 1'b1;
              // The register shifts on this edge, so bit 1 becomes bit 0.
              bsr_si   <= sr_q[1];
            end
          end
        end

        ST_UPDATE: begin
          state <= ST_DONE;
          done  <= 1'b1;
          rdata <= sr_q;
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
